// File: rtl/ps2_pkg.sv
// ps2_pkg
// Shared definitions for the PS/2 keyboard front end:
//   - scan-code constants used by the byte decoder and mode-flag logic
//   - frame-receiver FSM state encoding
package ps2_pkg;

    localparam logic [7:0] SC_F1    = 8'h05;
    localparam logic [7:0] SC_F2    = 8'h06;
    localparam logic [7:0] SC_F3    = 8'h04;
    localparam logic [7:0] SC_ESC   = 8'h76;
    localparam logic [7:0] SC_ENTER = 8'h5A;
    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } rx_state_t;

endpackage

// File: rtl/ps2_rx_frame.sv
// ps2_rx_frame
// Receives one 11-bit PS/2 frame at a time: synchronises ps2c/ps2d,
// glitch-filters ps2c, samples data on filtered falling edges, checks
// odd parity and the stop bit, and abandons stalled frames.
// Ports:
//   i_clk, i_rst_n     - system clock, asynchronous active-low reset
//   i_ps2c, i_ps2d     - raw asynchronous PS/2 clock and data
//   o_byte_valid       - one-cycle strobe, o_rx_byte holds a good byte
//   o_rx_byte          - received data byte (registered)
//   o_frame_err        - one-cycle strobe on parity/stop error or timeout
module ps2_rx_frame
    import ps2_pkg::*;
#(
    parameter int FILT        = 8,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_ps2c,
    input  logic       i_ps2d,
    output logic       o_byte_valid,
    output logic [7:0] o_rx_byte,
    output logic       o_frame_err
);

    localparam int CW = (FILT > 1) ? $clog2(FILT) : 1;
    localparam int WW = $clog2(TIMEOUT_CYC + 1);

    logic [1:0]    r_c_sync;
    logic [1:0]    r_d_sync;
    logic          r_filt;
    logic          r_filt_q;
    logic [CW-1:0] r_fcnt;

    rx_state_t     r_state;
    logic [2:0]    r_bitcnt;
    logic [7:0]    r_shift;
    logic          r_par;
    logic [WW-1:0] r_wd;

    logic          w_fall;
    logic          w_d;

    // Bus idles high, so synchronisers and filter reset to 1 to avoid a
    // false falling edge straight out of reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_c_sync <= 2'b11;
            r_d_sync <= 2'b11;
            r_filt   <= 1'b1;
            r_filt_q <= 1'b1;
            r_fcnt   <= '0;
        end else begin
            r_c_sync <= {r_c_sync[0], i_ps2c};
            r_d_sync <= {r_d_sync[0], i_ps2d};
            r_filt_q <= r_filt;
            // Flip the filtered level only after FILT consecutive samples
            // that disagree with it; any agreeing sample restarts the count.
            if (r_c_sync[1] != r_filt) begin
                if (r_fcnt == CW'(FILT - 1)) begin
                    r_filt <= r_c_sync[1];
                    r_fcnt <= '0;
                end else begin
                    r_fcnt <= r_fcnt + 1'b1;
                end
            end else begin
                r_fcnt <= '0;
            end
        end
    end

    assign w_fall = r_filt_q & ~r_filt;
    assign w_d    = r_d_sync[1];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= ST_IDLE;
            r_bitcnt     <= '0;
            r_shift      <= '0;
            r_par        <= 1'b0;
            r_wd         <= '0;
            o_byte_valid <= 1'b0;
            o_rx_byte    <= '0;
            o_frame_err  <= 1'b0;
        end else begin
            o_byte_valid <= 1'b0;
            o_frame_err  <= 1'b0;
            if (r_state == ST_IDLE) begin
                r_wd <= '0;
                // A falling edge with data high is a spurious edge: ignore.
                if (w_fall && !w_d) begin
                    r_state  <= ST_DATA;
                    r_bitcnt <= '0;
                end
            end else if (w_fall) begin
                r_wd <= '0;
                case (r_state)
                    ST_DATA: begin
                        r_shift  <= {w_d, r_shift[7:1]};
                        r_bitcnt <= r_bitcnt + 1'b1;
                        if (r_bitcnt == 3'd7) r_state <= ST_PARITY;
                    end
                    ST_PARITY: begin
                        r_par   <= w_d;
                        r_state <= ST_STOP;
                    end
                    ST_STOP: begin
                        if ((^{r_shift, r_par}) && w_d) begin
                            o_byte_valid <= 1'b1;
                            o_rx_byte    <= r_shift;
                        end else begin
                            o_frame_err  <= 1'b1;
                        end
                        r_state <= ST_IDLE;
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end else if (r_wd == WW'(TIMEOUT_CYC - 1)) begin
                // Keyboard stopped clocking mid-frame: drop the partial byte.
                r_state     <= ST_IDLE;
                r_wd        <= '0;
                o_frame_err <= 1'b1;
            end else begin
                r_wd <= r_wd + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder
// Keyboard front end for the time/date configuration path. Turns received
// PS/2 bytes into one key_code per key release, tracks the one-hot edit
// modes (f1 hour, f2 date, f3 timer) and raises listo_conf when Enter
// confirms an edit.
// Ports:
//   clk, rst           - system clock, asynchronous active-low reset
//   ps2c, ps2d         - raw PS/2 clock and data
//   I_ack              - interrupt acknowledge, clears listo_conf
//   key_code           - last released scan code (held between ticks)
//   got_code_tick      - one-cycle strobe, key_code valid same cycle
//   f1, f2, f3         - one-hot edit-mode flags
//   listo_conf         - sticky configuration-done request
//   frame_err          - one-cycle strobe on a rejected frame
module ps2_key_decoder
    import ps2_pkg::*;
#(
    parameter int FILT        = 8,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2c,
    input  logic       ps2d,
    input  logic       I_ack,
    output logic [7:0] key_code,
    output logic       got_code_tick,
    output logic       f1,
    output logic       f2,
    output logic       f3,
    output logic       listo_conf,
    output logic       frame_err
);

    logic       w_byte_valid;
    logic [7:0] w_rx_byte;
    logic       w_frame_err;
    logic       w_set_listo;
    logic       r_brk;

    ps2_rx_frame #(
        .FILT        (FILT),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_rx (
        .i_clk        (clk),
        .i_rst_n      (rst),
        .i_ps2c       (ps2c),
        .i_ps2d       (ps2d),
        .o_byte_valid (w_byte_valid),
        .o_rx_byte    (w_rx_byte),
        .o_frame_err  (w_frame_err)
    );

    assign frame_err = w_frame_err;

    // Only break codes produce a tick; E0 is transparent so extended keys
    // decode by their base code, and make/typematic bytes are dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_brk         <= 1'b0;
            key_code      <= '0;
            got_code_tick <= 1'b0;
        end else begin
            got_code_tick <= 1'b0;
            if (w_byte_valid) begin
                if (w_rx_byte == SC_BREAK) begin
                    r_brk <= 1'b1;
                end else if (w_rx_byte != SC_EXT && r_brk) begin
                    key_code      <= w_rx_byte;
                    got_code_tick <= 1'b1;
                    r_brk         <= 1'b0;
                end
            end
        end
    end

    assign w_set_listo = got_code_tick && (key_code == SC_ENTER) && (f1 | f2 | f3);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            f1 <= 1'b0;
            f2 <= 1'b0;
            f3 <= 1'b0;
        end else if (got_code_tick) begin
            case (key_code)
                SC_F1:    {f1, f2, f3} <= 3'b100;
                SC_F2:    {f1, f2, f3} <= 3'b010;
                SC_F3:    {f1, f2, f3} <= 3'b001;
                SC_ESC:   {f1, f2, f3} <= 3'b000;
                SC_ENTER: if (f1 | f2 | f3) {f1, f2, f3} <= 3'b000;
                default:  ;
            endcase
        end
    end

    // A new request beats a simultaneous acknowledge so it is never lost.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            listo_conf <= 1'b0;
        end else if (w_set_listo) begin
            listo_conf <= 1'b1;
        end else if (I_ack) begin
            listo_conf <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ps2_key_decoder.sv
module tb_ps2_key_decoder;

    localparam int FILT = 4;
    localparam int TO   = 200;

    logic       clk = 1'b0;
    logic       rst;
    logic       ps2c;
    logic       ps2d;
    logic       I_ack;
    logic [7:0] key_code;
    logic       got_code_tick, f1, f2, f3, listo_conf, frame_err;

    ps2_key_decoder #(.FILT(FILT), .TIMEOUT_CYC(TO)) dut (
        .clk           (clk),
        .rst           (rst),
        .ps2c          (ps2c),
        .ps2d          (ps2d),
        .I_ack         (I_ack),
        .key_code      (key_code),
        .got_code_tick (got_code_tick),
        .f1            (f1),
        .f2            (f2),
        .f3            (f3),
        .listo_conf    (listo_conf),
        .frame_err     (frame_err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int t_stop  = 0;
    int n_tick  = 0;
    int n_err   = 0;
    int n_both  = 0;
    int lat     = 0;
    logic [7:0] last_code = '0;
    logic [3:0] pre  = '0;
    logic [3:0] post = '0;
    logic       tick_d = 1'b0;
    int base_t, base_e;

    always @(posedge clk) cyc <= cyc + 1;

    // Event monitor, sampled away from the active edge.
    always @(negedge clk) begin
        tick_d <= got_code_tick;
        if (got_code_tick) begin
            n_tick    <= n_tick + 1;
            last_code <= key_code;
            lat       <= cyc - t_stop;
            pre       <= {f1, f2, f3, listo_conf};
        end
        if (tick_d) post <= {f1, f2, f3, listo_conf};
        if (frame_err) n_err <= n_err + 1;
        if (got_code_tick && frame_err) n_both <= n_both + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Frame: start, 8 data LSB first, odd parity (optionally corrupted), stop.
    task automatic send_frame(input logic [7:0] b, input logic bad_par, input int nbits);
        logic [10:0] f;
        f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2d = f[i];
            repeat (10) @(negedge clk);
            ps2c = 1'b0;
            if (i == 10) t_stop = cyc;
            repeat (10) @(negedge clk);
            ps2c = 1'b1;
        end
        ps2d = 1'b1;
        repeat (20) @(negedge clk);
    endtask

    task automatic key(input logic [7:0] b);
        send_frame(b, 1'b0, 11);
    endtask

    initial begin
        rst = 1'b0; ps2c = 1'b1; ps2d = 1'b1; I_ack = 1'b0;
        repeat (5) @(negedge clk);

        // Reset holds everything at zero even with bus activity.
        key(8'hF0); key(8'h05);
        chk("rst_outs", {key_code, got_code_tick, f1, f2, f3, listo_conf, frame_err}, 32'h0);
        chk("rst_ticks", n_tick + n_err, 0);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        chk("rel_outs", {key_code, got_code_tick, f1, f2, f3, listo_conf, frame_err}, 32'h0);

        // F1 release
        key(8'h05); key(8'hF0); key(8'h05);
        chk("f1_ntick", n_tick, 1);
        chk("f1_code", last_code, 8'h05);
        chk("f1_lat", lat, 2 + FILT + 2);
        chk("f1_pre", pre, 4'b0000);
        chk("f1_post", post, 4'b1000);

        // Mode switch, then Enter, then ack
        key(8'hF0); key(8'h06);
        chk("f2_flags", {f1, f2, f3}, 3'b010);
        chk("f2_post", post, 4'b0100);
        key(8'hF0); key(8'h5A);
        chk("enter", {f1, f2, f3, listo_conf}, 4'b0001);
        I_ack = 1'b1; @(negedge clk); I_ack = 1'b0; @(negedge clk);
        chk("ack", listo_conf, 1'b0);
        key(8'hF0); key(8'h5A);
        chk("enter_noflag", {f1, f2, f3, listo_conf}, 4'b0000);

        // Make code alone ignored; E0 prefix transparent; Esc clears.
        base_t = n_tick;
        key(8'h05);
        chk("make_ign", n_tick, base_t);
        key(8'hE0); key(8'hF0); key(8'h05);
        chk("ext_tick", n_tick, base_t + 1);
        chk("ext_flags", {f1, f2, f3}, 3'b100);
        key(8'hF0); key(8'h76);
        chk("esc", {f1, f2, f3}, 3'b000);

        // Bad parity: error, no tick, brk retained.
        base_t = n_tick; base_e = n_err;
        key(8'hF0);
        send_frame(8'h05, 1'b1, 11);
        chk("par_err", n_err, base_e + 1);
        chk("par_notick", n_tick, base_t);
        key(8'h05);
        chk("par_retick", n_tick, base_t + 1);
        chk("par_f1", {f1, f2, f3}, 3'b100);

        // Timeout after 4 bits
        base_e = n_err;
        send_frame(8'h00, 1'b0, 4);
        chk("to_early", n_err, base_e);
        repeat (TO + 20) @(negedge clk);
        chk("to_err", n_err, base_e + 1);
        key(8'hF0); key(8'h06);
        chk("to_f2", {f1, f2, f3}, 3'b010);

        // Collision: set and ack together -> set wins.
        I_ack = 1'b1;
        key(8'hF0); key(8'h5A);
        chk("coll_set", post[0], 1'b1);
        chk("coll_clr", listo_conf, 1'b0);
        I_ack = 1'b0;

        // Glitch of FILT-1 cycles with data low must not start a frame.
        base_e = n_err;
        ps2d = 1'b0; @(negedge clk);
        ps2c = 1'b0; repeat (FILT - 1) @(negedge clk);
        ps2c = 1'b1; repeat (4) @(negedge clk);
        ps2d = 1'b1;
        repeat (TO + 30) @(negedge clk);
        chk("glitch", n_err, base_e);
        key(8'hF0); key(8'h04);
        chk("glitch_f3", {f1, f2, f3}, 3'b001);

        // Reset mid-frame, then clean reception.
        key(8'hF0);
        base_t = n_tick; base_e = n_err;
        send_frame(8'hA5, 1'b0, 6);
        rst = 1'b0; repeat (3) @(negedge clk); rst = 1'b1;
        repeat (TO + 20) @(negedge clk);
        chk("mid_rst", {n_tick, n_err}, {base_t, base_e});
        key(8'hF0); key(8'h05);
        chk("mid_tick", n_tick, base_t + 1);
        chk("mid_f1", {f1, f2, f3}, 3'b100);

        chk("excl", n_both, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ps2_key_decoder.md
# ps2_key_decoder

Upstream keyboard front end for the time/date configuration path. Receives raw PS/2 frames from the keyboard, filters the PS/2 clock, validates each 11-bit frame, strips break/extended prefixes, and presents one registered `key_code` with a single-cycle `got_code_tick` per key release. It also maintains the one-hot edit-mode flags `f1`/`f2`/`f3` and the `listo_conf` interrupt request consumed by the position counter, field counters, output decoders and PicoBlaze interface.

## Interface
Parameters:
- `FILT` — default 8 — length of the ps2c glitch filter, in clk cycles.
- `TIMEOUT_CYC` — default 100000 — idle clk cycles inside a frame before it is abandoned.

Ports:
- `clk` — in — 1 — system clock; one clock domain.
- `rst` — in — 1 — asynchronous reset, active-low.
- `ps2c` — in — 1 — raw PS/2 clock, asynchronous.
- `ps2d` — in — 1 — raw PS/2 data, asynchronous.
- `I_ack` — in — 1 — interrupt acknowledge from PicoBlaze; level-sampled each cycle.
- `key_code` — out — 8 — last released scan code; holds its value between ticks.
- `got_code_tick` — out — 1 — one-cycle strobe; `key_code` is valid in the same cycle.
- `f1`, `f2`, `f3` — out — 1 each — one-hot edit modes: hour, date, timer.
- `listo_conf` — out — 1 — configuration-done interrupt request; sticky until acknowledged.
- `frame_err` — out — 1 — one-cycle strobe on a rejected frame.

## Operation
- **Synchroniser**
  - `ps2c` and `ps2d` each pass through a 2-FF synchroniser.
  - Filtered ps2c changes level only after FILT consecutive equal synchronised samples.
  - A falling edge of the filtered ps2c produces `fall`, a one-cycle internal pulse.
- **Frame FSM** (IDLE, DATA, PARITY, STOP), advanced only on `fall`:
  - IDLE: `ps2d`=0 → DATA with bit count 0. `ps2d`=1 → stay in IDLE (spurious edge, no error).
  - DATA: shift `ps2d` in LSB first. After the 8th bit → PARITY.
  - PARITY: capture the bit → STOP.
  - STOP: byte is valid if data plus parity has odd parity and stop=1. Otherwise pulse `frame_err` and drop the byte. Either way → IDLE.
- **Watchdog**
  - Outside IDLE, a counter increments every cycle without `fall` and clears on `fall`.
  - At TIMEOUT_CYC → IDLE, pulse `frame_err`, discard partial byte.
- **Byte decoder**, on each valid byte:
  - 0xE0: no flag change; byte is ignored.
  - 0xF0: set `brk`.
  - Any other byte with `brk`=1: `key_code`←byte, pulse `got_code_tick`, clear `brk`.
  - Any other byte with `brk`=0 (make or typematic repeat): ignored.
- **Mode flags**, updated on `got_code_tick`:
  - 0x05 (F1) → f1=1, f2=0, f3=0.
  - 0x06 (F2) → f2 only.
  - 0x04 (F3) → f3 only.
  - 0x76 (Esc) → all three cleared.
  - 0x5A (Enter) with any flag set → all flags cleared and `listo_conf`←1.
  - 0x5A with no flag set: no effect.
- **listo_conf**
  - Cleared when `I_ack`=1.
  - If a set and `I_ack` occur in the same cycle, the set wins.

## Timing
- Reset values: every output 0. FSM in IDLE; `brk`, bit count and watchdog at 0; filter and synchronisers at 1 (bus idle high).
- `rst` asserted mid-frame: frame is lost and no strobe is issued; reception restarts cleanly at the next start bit.
- Latency from ps2c falling at the stop bit to `got_code_tick`: 2 (sync) + FILT + 2 clk cycles.
- Flags and `listo_conf` update exactly 1 cycle after `got_code_tick`.
- `got_code_tick` and `frame_err` are never high together. Each is high for exactly 1 cycle.
- Only one byte is in flight at a time. Back-to-back frames need no buffering: byte decoding completes in 1 cycle.
- Pulses shorter than FILT cycles on ps2c are ignored.

## Structure
- Shared package `ps2_pkg` holds:
  - scan-code constants SC_F1=0x05, SC_F2=0x06, SC_F3=0x04, SC_ESC=0x76, SC_ENTER=0x5A, SC_BREAK=0xF0, SC_EXT=0xE0;
  - the frame-FSM state enum.
- Sub-module `ps2_rx_frame` contains synchronisers, filter, frame FSM and watchdog. It outputs `byte_valid`, `rx_byte` and `frame_err`.
- The top level contains only the byte decoder, mode flags and `listo_conf`.

## Test plan
- **Reset:** hold `rst`=0, toggle ps2c → all outputs 0; release → still 0.
- **F1 release:** send frames 0x05, 0xF0, 0x05 → one `got_code_tick` with `key_code`=0x05; f1=1, f2=f3=0 one cycle later.
- **Mode switch and Enter:** F1 release, then F2 release → f1=0, f2=1. Enter release → flags 0 and `listo_conf`=1. `I_ack` pulse → `listo_conf`=0.
- **Bad parity:** 0xF0 then 0x05 sent with even parity → `frame_err` pulse, no tick. The next correct 0x05 still ticks, because `brk` is retained.
- **Timeout:** stop ps2c after 4 bits; after TIMEOUT_CYC cycles → `frame_err`. A following full F0 06 sequence decodes normally and sets f2.
- **Collision and glitch:** Enter tick lands in the same cycle as `I_ack` → `listo_conf`=1. A ps2c glitch of FILT−1 cycles → no bit sampled.
